// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scanner family.
//   HEX_FONT  : 16-entry active-low font, bit order g..a (bit 6 = g, bit 0 = a)
//   SEG_OFF   : all segments and decimal point dark
//   sel_width : select/index width helper, never narrower than 1 bit
package seg_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Entry n is the glyph for nibble n; listed F down to 0 (MSB first).
   localparam logic [15:0][6:0] HEX_FONT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg_font.sv
// seg_font: combinational nibble -> active-low segment pattern.
//   nib_i   : hex digit to display
//   blank_i : 1 = segments g..a dark (decimal point unaffected)
//   dp_i    : 1 = decimal point lit
//   seg_o   : {dp, g..a}, active low
module seg_font
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       blank_i,
   input  logic       dp_i,
   output logic [7:0] seg_o
);

   assign seg_o = {~dp_i, (blank_i ? SEG_OFF[6:0] : HEX_FONT[nib_i])};

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multi-channel seven-segment scanner with per-frame snapshot.
//   clk        : system clock
//   rstn       : synchronous reset, active HIGH despite the name
//   ch_data    : NCH packed channels, channel k = ch_data[k*W +: W]
//   ch_sel     : channel select, out-of-range values pick channel 0
//   freeze     : 1 = keep current snapshot at frame end
//   seg        : active-low segments {dp, g..a}, registered
//   AN         : active-low anode enables, registered
//   frame_tick : one-cycle pulse after each snapshot load
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter  int NCH      = 4,
   parameter  int W        = 32,
   parameter  int DIGITS   = 8,
   parameter  int SCAN_DIV = 100000,
   parameter  int BLANK_LZ = 1,
   localparam int SELW     = sel_width(NCH)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NCH*W-1:0]    ch_data,
   input  logic [SELW-1:0]     ch_sel,
   input  logic                freeze,
   output logic [7:0]          seg,
   output logic [DIGITS-1:0]   AN,
   output logic                frame_tick
);

   localparam int SNW  = 4 * DIGITS;
   localparam int DIGW = sel_width(DIGITS);
   localparam int DIVW = $clog2(SCAN_DIV);

   if (W > SNW) begin : g_width_chk
      $error("seg_scan_mux: W must not exceed 4*DIGITS");
   end

   logic [DIVW-1:0]   div_q;
   logic [DIGW-1:0]   dig_q;
   logic [SNW-1:0]    snap_q, snap_d;
   logic [SELW-1:0]   snap_ch_q, eff_sel;
   logic [7:0]        seg_q, seg_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic              tick_q;

   logic [NCH-1:0][W-1:0]    chans;
   logic [DIGITS-1:0][3:0]   nibs;
   logic                     div_last, dig_last, load, cur_blank;

   assign chans    = ch_data;
   assign nibs     = snap_q;
   assign div_last = (div_q == DIVW'(SCAN_DIV - 1));
   assign dig_last = (dig_q == DIGW'(DIGITS - 1));
   assign load     = div_last && dig_last && !freeze;
   assign eff_sel  = (32'(ch_sel) < 32'(NCH)) ? ch_sel : '0;

   always_comb begin
      snap_d          = '0;
      snap_d[W-1:0]   = chans[eff_sel];
   end

   // Current digit is dark when it and every digit above it are zero;
   // digit 0 always shows so a zero value reads "0".
   always_comb begin
      cur_blank = 1'b0;
      if (BLANK_LZ != 0 && dig_q != '0) begin
         cur_blank = 1'b1;
         for (int d = 0; d < DIGITS; d++) begin
            if (32'(d) >= 32'(dig_q) && nibs[d] != 4'h0) cur_blank = 1'b0;
         end
      end
   end

   // snap_ch >= DIGITS never matches a digit index, so no dp is lit then.
   seg_font u_font (
      .nib_i   (nibs[dig_q]),
      .blank_i (cur_blank),
      .dp_i    (32'(snap_ch_q) == 32'(dig_q)),
      .seg_o   (seg_d)
   );

   assign an_d = ~(DIGITS'(1) << dig_q);

   always_ff @(posedge clk) begin
      if (rstn) begin
         div_q     <= '0;
         dig_q     <= '0;
         snap_q    <= '0;
         snap_ch_q <= '0;
         seg_q     <= SEG_OFF;
         an_q      <= '1;
         tick_q    <= 1'b0;
      end else begin
         div_q <= div_last ? '0 : div_q + DIVW'(1);
         if (div_last) dig_q <= dig_last ? '0 : dig_q + DIGW'(1);
         if (load) begin
            snap_q    <= snap_d;
            snap_ch_q <= eff_sel;
         end
         tick_q <= load;
         // Outputs follow the pre-edge digit/snapshot, so anode and
         // segments switch together on one edge.
         seg_q  <= seg_d;
         an_q   <= an_d;
      end
   end

   assign seg        = seg_q;
   assign AN         = an_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench: two scanners (leading-zero blanking on/off) share inputs.
// The driver predicts every output cycle from a frame/digit view of time and
// queues it; the monitor pops one entry per clock and compares.
module tb_seg_scan_mux;

   localparam int NCH = 3, W = 32, DIG = 8, SD = 4, P = DIG * SD;

   logic            clk = 1'b0;
   logic            rstn;
   logic [NCH*W-1:0] ch_data;
   logic [1:0]      ch_sel;
   logic            freeze;
   logic [7:0]      seg_a, seg_b, an_a, an_b;
   logic            tick_a, tick_b;

   always #5 clk = ~clk;

   seg_scan_mux #(.NCH(NCH), .W(W), .DIGITS(DIG), .SCAN_DIV(SD), .BLANK_LZ(1)) dut_a (
      .clk(clk), .rstn(rstn), .ch_data(ch_data), .ch_sel(ch_sel), .freeze(freeze),
      .seg(seg_a), .AN(an_a), .frame_tick(tick_a));

   seg_scan_mux #(.NCH(NCH), .W(W), .DIGITS(DIG), .SCAN_DIV(SD), .BLANK_LZ(0)) dut_b (
      .clk(clk), .rstn(rstn), .ch_data(ch_data), .ch_sel(ch_sel), .freeze(freeze),
      .seg(seg_b), .AN(an_b), .frame_tick(tick_b));

   typedef struct packed {
      logic [7:0] seg_a;
      logic [7:0] seg_b;
      logic [7:0] an;
      logic       tick;
   } exp_t;

   exp_t q[$];
   int   checks = 0, errors = 0;
   bit   running = 0;

   logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // model state: edges since reset, value/channel currently displayed
   int          k = 0;
   logic [31:0] m_snap = 0;
   int          m_ch = 0;

   function automatic logic [7:0] ref_seg(logic [31:0] v, int ch, int d, bit blz);
      logic [31:0] hi;
      logic [6:0]  s;
      hi = v >> (4 * d);
      s  = (blz && d != 0 && hi == 0) ? 7'h7F : font[hi[3:0]];
      return {(d == ch) ? 1'b0 : 1'b1, s};
   endfunction

   task automatic push_exp();
      exp_t e;
      int   d, es;
      if (rstn) begin
         k = 0; m_snap = 0; m_ch = 0;
         e = '{seg_a: 8'hFF, seg_b: 8'hFF, an: 8'hFF, tick: 1'b0};
      end else begin
         k++;
         d      = ((k - 1) / SD) % DIG;
         e.an   = ~(8'd1 << d);
         e.seg_a = ref_seg(m_snap, m_ch, d, 1'b1);
         e.seg_b = ref_seg(m_snap, m_ch, d, 1'b0);
         e.tick = 1'b0;
         if (k % P == 0 && !freeze) begin
            es     = (ch_sel < NCH) ? int'(ch_sel) : 0;
            m_snap = ch_data[es*W +: W];
            m_ch   = es;
            e.tick = 1'b1;
         end
      end
      q.push_back(e);
   endtask

   task automatic cyc();
      push_exp();
      @(negedge clk);
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] rnd_val();
      logic [31:0] v;
      int sh;
      v  = $urandom;
      sh = $urandom_range(0, 8);
      return (sh == 8) ? 32'h0 : (v >> (4 * sh));
   endfunction

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (running) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty at %0t: got none expected entry", $time);
         end else begin
            e = q.pop_front();
            chk("seg_blank",   seg_a, e.seg_a);
            chk("seg_noblank", seg_b, e.seg_b);
            chk("an_a",        an_a,  e.an);
            chk("an_b",        an_b,  e.an);
            chk("tick_a",      {7'd0, tick_a}, {7'd0, e.tick});
            chk("tick_b",      {7'd0, tick_b}, {7'd0, e.tick});
         end
      end
   end

   initial begin
      rstn = 1'b1; ch_data = '0; ch_sel = '0; freeze = 1'b0;
      @(negedge clk);
      running = 1;
      run(2);
      // first frame: channel 2 = 1A3F, then mid-frame change must not tear
      rstn = 1'b0;
      ch_data[0*W +: W] = 32'h1234_5678;
      ch_data[1*W +: W] = 32'h0000_00C0;
      ch_data[2*W +: W] = 32'h0000_1A3F;
      ch_sel = 2'd2;
      run(40);
      ch_data[2*W +: W] = 32'h0000_0005;
      run(60);
      // freeze holds snapshot across frame ends
      freeze = 1'b1;
      ch_data[2*W +: W] = 32'h0000_BEEF;
      run(70);
      freeze = 1'b0;
      run(40);
      // out-of-range select falls back to channel 0, value zero
      ch_sel = 2'd3;
      ch_data[0*W +: W] = 32'h0;
      run(70);
      ch_sel = 2'd1;
      run(40);
      // reset while digit 5 is being driven
      for (int i = 0; i < P && ((k / SD) % DIG) != 5; i++) cyc();
      rstn = 1'b1;
      cyc();
      rstn = 1'b0;
      run(40);
      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 11) == 0) ch_data[$urandom_range(0, NCH-1)*W +: W] = rnd_val();
         if ($urandom_range(0, 19) == 0) ch_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) freeze = ~freeze;
         rstn = ($urandom_range(0, 399) == 0);
         cyc();
      end
      running = 0;
      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised multi-channel seven-segment scanner, successor to the single-counter `segment` driver at the board top. It accepts `NCH` packed data channels (cycle count, retired instructions, PC, debug word, ...), selects one with `ch_sel`, and snapshots it once per scan frame so digits never tear. It scans `DIGITS` active-low anodes with leading-zero blanking, a channel-indicator decimal point and a freeze mode. It sits beside the CPU/SDU in the top level and drives `seg`/`AN` directly.

## Interface
- `NCH`, 4: number of input channels (≥1).
- `W`, 32: channel width in bits; elaboration error unless `W ≤ 4*DIGITS`.
- `DIGITS`, 8: number of digits/anodes (1..8).
- `SCAN_DIV`, 100000: clk cycles each digit stays lit (≥2).
- `BLANK_LZ`, 1: 1 = blank leading zero digits, 0 = show all digits.
- `clk`  in  1  single system clock; everything is synchronous to it.
- `rstn`  in  1  one clock `clk`; reset `rstn` is synchronous and active-high.
- `ch_data`  in  NCH*W  packed channels; channel k = `ch_data[k*W +: W]`.
- `ch_sel`  in  max(1,$clog2(NCH))  channel select; values ≥ NCH select channel 0.
- `freeze`  in  1  1 = hold the current snapshot; scanning continues.
- `seg`  out  8  active-low segments, [6:0] = g..a, [7] = decimal point.
- `AN`  out  DIGITS  active-low anode enables; exactly one low outside reset.
- `frame_tick`  out  1  one-cycle pulse when a snapshot load occurs.

## Operation
- Divider `div` counts 0..SCAN_DIV-1 and wraps. At `div == SCAN_DIV-1`, digit index `dig` advances 0→1→…→DIGITS-1→0.
- Frame end = `div == SCAN_DIV-1 && dig == DIGITS-1`. At frame end, if `freeze == 0`: `snap <= selected channel` (zero-extended to 4*DIGITS), `snap_ch <= effective ch_sel`, and `frame_tick` pulses. If `freeze == 1`: no load and no pulse.
- Digit d shows nibble `snap[4d+3:4d]` through the shared hex font (0-F).
- Blanking (BLANK_LZ=1): digit d is dark (segments [6:0] all 1) when d ≠ 0 and all nibbles above and including d are zero. Digit 0 is never blanked, so value 0 displays as "0".
- Decimal point is lit (seg[7]=0) on digit d iff `d == snap_ch`, and only if `snap_ch < DIGITS`. This holds even when the digit is blanked.
- A `ch_sel` or `freeze` change mid-frame affects only the next frame-end decision.

## Timing
- Reset values: `div=0`, `dig=0`, `snap=0`, `snap_ch=0`, `seg=8'hFF`, `AN` all 1, `frame_tick=0`.
- `seg` and `AN` are registered with one-cycle latency from `dig`/`snap`. The first clock after reset deassertion drives digit 0 of snapshot 0: AN[0]=0, seg = font('0') with dp lit (= 8'h40).
- Snapshot load takes effect at the clock edge at frame end. `frame_tick` is high in the cycle after that edge. New data appears on digit 0 one cycle later, because `seg` is registered.
- Frame period is DIGITS*SCAN_DIV cycles. The first load occurs at the edge ending cycle DIGITS*SCAN_DIV-1 after reset.
- Reset asserted mid-frame: all state returns to reset values on that edge, and the frame restarts from digit 0.
- Anode switch: AN and seg change on the same edge, with no all-off gap cycle.

## Structure
- Package `seg_pkg`: 16-entry hex font constant (active-low, g..a), `SEG_OFF = 8'hFF`, and the elaboration helper for select width.
- One sub-module, `seg_font`: combinational nibble + blank + dp → 8-bit active-low pattern. It is shared with the legacy `segment` driver.
- Top of block: divider/digit counter, snapshot register, blanking-mask logic, and output registers.

## Test plan
- Reset and first digit, with SCAN_DIV=4, DIGITS=8, NCH=4, W=32: release reset → next cycle AN=8'hFE, seg=8'h40. AN rotates to 8'hFD after 4 cycles.
- Snapshot: ch_data channel 2 = 32'h0000_1A3F, ch_sel=2, run 1 frame → frame_tick pulses once at cycle 32. The next frame shows digits 0..3 = F,3,A,1 and digits 4..7 dark. The dp is on digit 2 only.
- No tearing: change channel 2 to 32'h0000_0005 at cycle 40 (mid-frame) → the current frame still shows 1A3F. The following frame shows "5" with 7 blank digits.
- Freeze: assert freeze before frame end and change data → no frame_tick, and the display is unchanged. Deassert freeze → the new value loads at the next frame end.
- Out-of-range select, with NCH=3 and ch_sel=3 → channel 0 is displayed and the dp is on digit 0. With BLANK_LZ=0, value 32'h0 → all 8 digits show "0".
- Reset mid-frame at digit 5 → the next cycle gives AN=8'hFE, snap=0 and seg=8'h40. frame_tick stays low until a full new frame completes.
